// File: rtl/mem_req_seq.sv
// Memory request sequencer: turns one load/store request into a single aligned
// access or a sequence of byte accesses, then holds a response until consumed.
module mem_req_seq #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ena,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_store_data,
  input  logic [31:0]       mem_load_data
);

  typedef enum logic [1:0] {IDLE, SINGLE, SPLIT, RESP} state_e;

  state_e              state_q;
  logic                we_q;
  logic [2:0]          func3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [1:0]          cnt_q;
  logic [31:0]         asm_q;
  logic                rsp_valid_q, rsp_err_q, mem_ena_q;
  logic [31:0]         rsp_rdata_q, mem_sd_q;
  logic [2:0]          mem_func3_q;
  logic [ADDR_W-1:0]   mem_addr_q;

  logic                legal_in, aligned_in;
  logic [1:0]          cnt_d, last_k;
  logic [31:0]         asm_d, ld_ext;

  assign req_ready      = (state_q == IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign mem_ena        = mem_ena_q;
  assign mem_func3      = mem_func3_q;
  assign mem_addr       = mem_addr_q;
  assign mem_store_data = mem_sd_q;

  always_comb begin
    legal_in = 1'b0;
    case (req_func3)
      3'b000, 3'b001, 3'b010: legal_in = 1'b1;
      3'b100, 3'b101:         legal_in = !req_we;
      default:                legal_in = 1'b0;
    endcase
  end

  always_comb begin
    aligned_in = 1'b0;
    case (req_func3[1:0])
      2'b00:   aligned_in = 1'b1;
      2'b01:   aligned_in = !req_addr[0];
      2'b10:   aligned_in = (req_addr[1:0] == 2'b00);
      default: aligned_in = 1'b0;
    endcase
  end

  // Split transfers are only ever halves (2 bytes) or words (4 bytes).
  assign last_k = func3_q[1] ? 2'd3 : 2'd1;
  assign cnt_d  = cnt_q + 2'd1;

  always_comb begin
    asm_d = asm_q;
    asm_d[{cnt_q, 3'b000} +: 8] = mem_load_data[7:0];
  end

  always_comb begin
    case (func3_q)
      3'b001:  ld_ext = {{16{asm_d[15]}}, asm_d[15:0]};
      3'b101:  ld_ext = {16'h0, asm_d[15:0]};
      default: ld_ext = asm_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      func3_q     <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      cnt_q       <= 2'd0;
      asm_q       <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_ena_q   <= 1'b0;
      mem_func3_q <= 3'b000;
      mem_addr_q  <= '0;
      mem_sd_q    <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          func3_q <= req_func3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          cnt_q   <= 2'd0;
          if (!legal_in) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'h0;
          end else if (aligned_in) begin
            state_q     <= SINGLE;
            mem_ena_q   <= req_we;
            mem_func3_q <= req_func3;
            mem_addr_q  <= req_addr;
            mem_sd_q    <= req_wdata;
          end else begin
            state_q     <= SPLIT;
            mem_ena_q   <= req_we;
            mem_func3_q <= req_we ? 3'b000 : 3'b100;
            mem_addr_q  <= req_addr;
            mem_sd_q    <= {24'h0, req_wdata[7:0]};
          end
        end
        SINGLE: begin
          state_q     <= RESP;
          mem_ena_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= we_q ? 32'h0 : mem_load_data;
        end
        SPLIT: begin
          if (!we_q) asm_q <= asm_d;
          if (cnt_q == last_k) begin
            state_q     <= RESP;
            mem_ena_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? 32'h0 : ld_ext;
          end else begin
            cnt_q      <= cnt_d;
            mem_ena_q  <= we_q;
            mem_addr_q <= addr_q + ADDR_W'(cnt_d);
            mem_sd_q   <= {24'h0, wdata_q[{cnt_d, 3'b000} +: 8]};
          end
        end
        RESP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_seq.sv
// Bench for mem_req_seq: byte-array memory environment, transaction-level
// reference model, and a per-cycle compare process on the falling edge.
module tb_mem_req_seq;
  localparam int AW  = 6;
  localparam int MSZ = 64;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [2:0]    req_func3 = 3'b000;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          req_ready, rsp_valid, rsp_err, mem_ena;
  logic [31:0]   rsp_rdata, mem_store_data, mem_load_data;
  logic [2:0]    mem_func3;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_req_seq #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_ena(mem_ena), .mem_func3(mem_func3), .mem_addr(mem_addr),
    .mem_store_data(mem_store_data), .mem_load_data(mem_load_data)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_vec++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b010:  return raw;
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Memory environment: combinational read, write on posedge when enabled.
  logic [7:0] mem [MSZ];
  logic       mem_inited = 1'b0;
  int         ena_cnt = 0;

  always_comb begin
    logic [31:0] raw;
    raw = 32'h0;
    for (int k = 0; k < 4; k++) raw[8*k +: 8] = mem[AW'(mem_addr + AW'(k))];
    mem_load_data = ext(raw, mem_func3);
  end

  always @(posedge clk) begin
    if (!rst_n && !mem_inited) begin
      for (int i = 0; i < MSZ; i++) mem[i] <= pat(i);
      mem_inited <= 1'b1;
    end else if (mem_ena === 1'b1) begin
      ena_cnt <= ena_cnt + 1;
      for (int k = 0; k < 4; k++)
        if (k < (1 << mem_func3[1:0])) mem[AW'(mem_addr + AW'(k))] <= mem_store_data[8*k +: 8];
    end
  end

  // Expected per-cycle outputs, maintained by the stimulus thread.
  typedef struct {
    bit          on, rdy, ena, sd_chk, valid, err;
    logic [5:0]  addr;
    logic [2:0]  f3;
    logic [31:0] sd, rdata;
  } exp_t;
  exp_t e;

  always @(negedge clk) if (e.on) begin
    chk("req_ready", 32'(req_ready), 32'(e.rdy));
    chk("mem_ena",   32'(mem_ena),   32'(e.ena));
    chk("mem_addr",  32'(mem_addr),  32'(e.addr));
    chk("mem_func3", 32'(mem_func3), 32'(e.f3));
    if (e.sd_chk) chk("mem_store_data", mem_store_data, e.sd);
    chk("rsp_valid", 32'(rsp_valid), 32'(e.valid));
    if (e.valid) begin
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err",   32'(rsp_err), 32'(e.err));
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [MSZ];
  logic [5:0]  last_addr;
  logic [2:0]  last_f3;
  logic [31:0] last_sd;
  bit          sd_known;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_idle;
    e.rdy = 1; e.ena = 0; e.valid = 0; e.err = 0; e.rdata = 0;
    e.addr = last_addr; e.f3 = last_f3; e.sd = last_sd; e.sd_chk = sd_known;
  endtask

  task automatic txn(input bit we, input logic [2:0] f3, input logic [5:0] a,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] got_rd, output logic got_err);
    bit legal;
    int sz, nacc;
    logic [31:0] raw, erd;
    legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    sz    = 1 << f3[1:0];
    nacc  = !legal ? 0 : ((32'(a) % sz) == 0) ? 1 : sz;
    raw   = 32'h0;
    for (int k = 0; k < 4; k++) raw[8*k +: 8] = ref_mem[6'(a + 6'(k))];
    erd   = (!legal || we) ? 32'h0 : ext(raw, f3);

    req_valid = 1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
    tick;
    req_valid = 0;
    for (int k = 0; k < nacc; k++) begin
      if (nacc == 1) begin
        last_addr = a; last_f3 = f3; last_sd = wd; sd_known = 1;
        if (we) for (int j = 0; j < sz; j++) ref_mem[6'(a + 6'(j))] = wd[8*j +: 8];
      end else begin
        last_addr = 6'(a + 6'(k)); last_f3 = we ? 3'b000 : 3'b100;
        last_sd = {24'h0, wd[8*k +: 8]}; sd_known = we;
        if (we) ref_mem[last_addr] = wd[8*k +: 8];
      end
      set_idle; e.rdy = 0; e.ena = we;
      tick;
    end
    set_idle; e.rdy = 0; e.valid = 1; e.rdata = erd; e.err = !legal;
    // A request offered during the response must not be taken.
    req_valid = 1;
    @(negedge clk);
    got_rd = rsp_rdata; got_err = rsp_err;
    repeat (hold) tick;
    rsp_ready = 1;
    tick;
    rsp_ready = 0; req_valid = 0;
    set_idle;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          c0;
    e = '{default: '0};
    for (int i = 0; i < MSZ; i++) ref_mem[i] = pat(i);

    // Reset state
    #2;
    chk("rst mem_ena", 32'(mem_ena), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst rsp_err", 32'(rsp_err), 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_func3", 32'(mem_func3), 0);
    chk("rst mem_store_data", mem_store_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    last_addr = 0; last_f3 = 0; last_sd = 0; sd_known = 1;
    set_idle; e.on = 1;
    tick;

    // Aligned word store then load
    c0 = ena_cnt;
    txn(1, 3'b010, 6'd8, 32'hAABBCCDD, 0, rd, er);
    chk("SW@8 ena pulses", 32'(ena_cnt - c0), 1);
    txn(0, 3'b010, 6'd8, 32'h0, 0, rd, er);
    chk("LW@8 data", rd, 32'hAABBCCDD);

    // Misaligned word store/load
    c0 = ena_cnt;
    txn(1, 3'b010, 6'd13, 32'h11223344, 1, rd, er);
    chk("SW@13 ena pulses", 32'(ena_cnt - c0), 4);
    txn(0, 3'b010, 6'd13, 32'h0, 0, rd, er);
    chk("LW@13 data", rd, 32'h11223344);

    // Wrap-around halfword
    txn(1, 3'b000, 6'd63, 32'h0000000D, 0, rd, er);
    txn(1, 3'b000, 6'd0, 32'h000000F0, 0, rd, er);
    txn(0, 3'b001, 6'd63, 32'h0, 0, rd, er);
    chk("LH@63 data", rd, 32'hFFFFF00D);
    txn(0, 3'b101, 6'd63, 32'h0, 0, rd, er);
    chk("LHU@63 data", rd, 32'h0000F00D);

    // Illegal func3
    c0 = ena_cnt;
    txn(0, 3'b011, 6'd4, 32'h0, 0, rd, er);
    chk("ill load err", 32'(er), 1);
    chk("ill load rdata", rd, 0);
    txn(1, 3'b100, 6'd4, 32'hDEADBEEF, 0, rd, er);
    chk("ill store err", 32'(er), 1);
    chk("ill store rdata", rd, 0);
    chk("ill ena pulses", 32'(ena_cnt - c0), 0);

    // Backpressure: response held three cycles, then back-to-back request
    txn(0, 3'b010, 6'd8, 32'h0, 3, rd, er);
    chk("held LW data", rd, 32'hAABBCCDD);
    txn(0, 3'b100, 6'd9, 32'h0, 0, rd, er);
    chk("LBU@9 data", rd, 32'h000000CC);

    // Reset in the middle of a split store
    req_valid = 1; req_we = 1; req_func3 = 3'b010; req_addr = 6'd1; req_wdata = 32'hA1B2C3D4;
    tick;
    req_valid = 0;
    last_addr = 1; last_f3 = 0; last_sd = 32'hD4; sd_known = 1;
    set_idle; e.rdy = 0; e.ena = 1;
    tick;
    ref_mem[1] = 8'hD4;
    last_addr = 2; last_sd = 32'hC3;
    set_idle; e.rdy = 0; e.ena = 1;
    @(negedge clk);
    #2;
    rst_n = 0; e.on = 0;
    #1;
    chk("mid-rst mem_ena", 32'(mem_ena), 0);
    chk("mid-rst rsp_valid", 32'(rsp_valid), 0);
    chk("mid-rst mem_addr", 32'(mem_addr), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    last_addr = 0; last_f3 = 0; last_sd = 0; sd_known = 1;
    set_idle; e.on = 1;
    tick;
    chk("rst byte@1", 32'(mem[1]), 32'hD4);
    chk("rst byte@2 untouched", 32'(mem[2]), 32'(pat(2)));

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      txn(1'($urandom_range(0, 1)), f3, 6'($urandom_range(0, 63)), $urandom,
          int'($urandom_range(0, 2)), rd, er);
      if ($urandom_range(0, 3) == 0) tick;
    end

    for (int i = 0; i < MSZ; i++) chk("final mem byte", 32'(mem[i]), 32'(ref_mem[i]));

    e.on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
